// File: rtl/fpga_video_top.sv
// FPGA video path top: VGA-style timing generator with a 16-px white grid on black,
// plus status LEDs. The hardware-support bus is held idle in this revision.
module fpga_video_top #(
    parameter int HDISP      = 800,
    parameter int VDISP      = 480,
    parameter int HFP        = 40,
    parameter int HPULSE     = 48,
    parameter int HBP        = 40,
    parameter int VFP        = 13,
    parameter int VPULSE     = 3,
    parameter int VBP        = 29,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic        FPGA_CLK1_50,
    input  logic [1:0]  KEY,
    input  logic [3:0]  SW,
    output logic [7:0]  LED,
    // hws_if master side
    output logic        hws_req_o,
    output logic        hws_wr_o,
    output logic [15:0] hws_addr_o,
    output logic [31:0] hws_wdata_o,
    // video_if source side
    output logic        vid_clk_o,
    output logic        vid_rst_o,
    output logic        vga_hs_o,
    output logic        vga_vs_o,
    output logic        vga_blank_o,
    output logic        vga_sync_o,
    output logic [23:0] vga_rgb_o
);

    localparam int HTOT     = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT     = VDISP + VFP + VPULSE + VBP;
    localparam int HW       = $clog2(HTOT);
    localparam int VW       = $clog2(VTOT);
    localparam int BW       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int HSYNC_LO = HDISP + HFP;
    localparam int HSYNC_HI = HDISP + HFP + HPULSE;
    localparam int VSYNC_LO = VDISP + VFP;
    localparam int VSYNC_HI = VDISP + VFP + VPULSE;

    logic          key_meta_q;
    logic          rst_n_q;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [3:0]    sw_q;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          active_s;
    logic          grid_s;
    logic          unused_key_s;

    // Two-flop synchroniser forming the internal reset from KEY[0]; these flops are never reset.
    always_ff @(posedge FPGA_CLK1_50) begin
        key_meta_q <= KEY[0];
        rst_n_q    <= key_meta_q;
    end

    // Raster position: hcnt wraps each line, vcnt advances on hcnt wrap and wraps each frame.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hcnt_q == HW'(HTOT - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == VW'(VTOT - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end
    end

    // Video decode of the current position; registered below so outputs lag the counters by one cycle.
    always_comb begin
        active_s = (hcnt_q < HW'(HDISP)) && (vcnt_q < VW'(VDISP));
        grid_s   = (hcnt_q[3:0] == 4'd0) || (vcnt_q[3:0] == 4'd0);
        hs_d     = !((hcnt_q >= HW'(HSYNC_LO)) && (hcnt_q < HW'(HSYNC_HI)));
        vs_d     = !((vcnt_q >= VW'(VSYNC_LO)) && (vcnt_q < VW'(VSYNC_HI)));
        blank_d  = active_s;
        if (active_s && grid_s) begin
            rgb_d = 24'hFF_FFFF;
        end else begin
            rgb_d = 24'h00_0000;
        end
    end

    // Heartbeat LED: toggles after every BLINK_HALF cycles out of reset.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_d     = blink_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!rst_n_q) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            sw_q        <= 4'd0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            rgb_q       <= 24'h00_0000;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            sw_q        <= SW;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            rgb_q       <= rgb_d;
        end
    end

    // LED[0] mirrors the raw reset key so the button state is visible even while held in reset.
    assign LED          = {2'b00, sw_q, blink_q, KEY[0]};
    assign unused_key_s = KEY[1];

    assign hws_req_o    = 1'b0;
    assign hws_wr_o     = 1'b0;
    assign hws_addr_o   = 16'h0000;
    assign hws_wdata_o  = 32'h0000_0000;

    assign vid_clk_o    = FPGA_CLK1_50;
    assign vid_rst_o    = rst_n_q;
    assign vga_hs_o     = hs_q;
    assign vga_vs_o     = vs_q;
    assign vga_blank_o  = blank_q;
    assign vga_sync_o   = 1'b0;
    assign vga_rgb_o    = rgb_q;

endmodule

// File: tb/tb_fpga_video_top.sv
// Directed bench for fpga_video_top with a raster-position model and line/frame timing measurement.
module tb_fpga_video_top;

    localparam int HDISP = 160;
    localparam int VDISP = 90;
    localparam int HTOT  = 288;
    localparam int VTOT  = 135;
    localparam int FRAME = HTOT * VTOT;
    localparam int BLINK = 10;

    logic        clk = 1'b0;
    logic [1:0]  key;
    logic [3:0]  sw;
    logic [7:0]  led;
    logic        hws_req, hws_wr;
    logic [15:0] hws_addr;
    logic [31:0] hws_wdata;
    logic        vid_clk, vid_rst, hs, vs, blank, vsync;
    logic [23:0] rgb;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #10 clk = ~clk;

    fpga_video_top #(
        .HDISP(HDISP), .VDISP(VDISP), .BLINK_HALF(BLINK)
    ) dut (
        .FPGA_CLK1_50(clk), .KEY(key), .SW(sw), .LED(led),
        .hws_req_o(hws_req), .hws_wr_o(hws_wr), .hws_addr_o(hws_addr), .hws_wdata_o(hws_wdata),
        .vid_clk_o(vid_clk), .vid_rst_o(vid_rst), .vga_hs_o(hs), .vga_vs_o(vs),
        .vga_blank_o(blank), .vga_sync_o(vsync), .vga_rgb_o(rgb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pos is the raster index whose video is on the outputs (-1 while held in reset).
    logic       m_s1 = 1'b0, m_s2 = 1'b0;
    int         pos   = -1;
    int         n_run = 0;
    logic [3:0] e_sw  = 4'd0;

    always @(posedge clk) begin
        if (!m_s2) begin
            pos = -1; n_run = 0; e_sw = 4'd0;
        end else begin
            pos = (pos < 0) ? 0 : (pos + 1) % FRAME;
            n_run++;
            e_sw = sw;
        end
        m_s2 = m_s1;
        m_s1 = key[0];
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        int x, y;
        logic act;
        logic [23:0] e_rgb;
        if (chk_en) begin
            x = (pos < 0) ? 0 : pos % HTOT;
            y = (pos < 0) ? 0 : pos / HTOT;
            act = (pos >= 0) && (x < HDISP) && (y < VDISP);
            e_rgb = (act && (x % 16 == 0 || y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
            chk("hs",    {31'd0, hs},    (pos < 0) ? 32'd1 : {31'd0, !(x >= 200 && x < 248)});
            chk("vs",    {31'd0, vs},    (pos < 0) ? 32'd1 : {31'd0, !(y >= 103 && y < 106)});
            chk("blank", {31'd0, blank}, {31'd0, act});
            chk("rgb",   {8'd0, rgb},    {8'd0, e_rgb});
            chk("sync",  {31'd0, vsync}, 32'd0);
            chk("rst",   {31'd0, vid_rst}, {31'd0, m_s2});
            chk("vclk",  {31'd0, vid_clk}, {31'd0, clk});
            chk("led",   {24'd0, led}, {24'd0, 2'b00, e_sw, 1'(((n_run / BLINK) % 2) != 0), key[0]});
            chk("hws",   {hws_addr, 14'd0, hws_req, hws_wr} | hws_wdata, 32'd0);
            if (pos == 0)               chk("px0_0",  {8'd0, rgb}, 32'h00FFFFFF);
            if (pos == 5 * HTOT + 16)   chk("px16_5", {8'd0, rgb}, 32'h00FFFFFF);
            if (pos == 32 * HTOT + 5)   chk("px5_32", {8'd0, rgb}, 32'h00FFFFFF);
            if (pos == 5 * HTOT + 5)    chk("px5_5",  {8'd0, rgb}, 32'h00000000);
            if (pos >= 0 && !blank)     chk("rgb_blank", {8'd0, rgb}, 32'd0);
            if (n_run == BLINK - 1)     chk("led1_9",  {31'd0, led[1]}, 32'd0);
            if (n_run == BLINK)         chk("led1_10", {31'd0, led[1]}, 32'd1);
            if (n_run == 2 * BLINK)     chk("led1_20", {31'd0, led[1]}, 32'd0);
        end
    end

    // Line and frame timing measured purely from DUT output edges.
    int cyc = 0, hs_fall = -1, vs_fall = -1, bl_rise = -1;
    int lines = 0, rows = 0, wcnt = 0, vs_n = 0;
    logic p_hs = 1'b1, p_vs = 1'b1, p_bl = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!chk_en || pos < 0) begin
            hs_fall = -1; vs_fall = -1; bl_rise = -1;
            lines = 0; rows = 0; wcnt = 0; vs_n = 0;
            p_hs = 1'b1; p_vs = 1'b1; p_bl = 1'b0;
        end else begin
            if (blank && rgb == 24'hFFFFFF) wcnt++;
            if (blank && !p_bl) begin
                bl_rise = cyc; lines++;
            end
            if (!blank && p_bl) begin
                chk("blank_width", cyc - bl_rise, 32'd160);
                if (wcnt == HDISP) rows++;
                else chk("grid_cols", wcnt, 32'd10);
                wcnt = 0;
            end
            if (!hs && p_hs) begin
                if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, 32'd288);
                if (bl_rise >= 0 && cyc - bl_rise < HTOT) chk("blank_to_hs", cyc - bl_rise, 32'd200);
                hs_fall = cyc;
            end
            if (hs && !p_hs && hs_fall >= 0) chk("hs_low", cyc - hs_fall, 32'd48);
            if (!vs && p_vs) begin
                if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, 32'd38880);
                else chk("vs_first", n_run, 32'd29665);
                chk("active_lines", lines, 32'd90);
                chk("grid_rows", rows, 32'd6);
                lines = 0; rows = 0;
                vs_fall = cyc; vs_n++;
            end
            if (vs && !p_vs && vs_fall >= 0) chk("vs_low", cyc - vs_fall, 32'd864);
            p_hs = hs; p_vs = vs; p_bl = blank;
        end
    end

    task automatic reset_pulse();
        @(posedge clk); #2 key[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_hs",    {31'd0, hs},    32'd1);
        chk("rst_vs",    {31'd0, vs},    32'd1);
        chk("rst_blank", {31'd0, blank}, 32'd0);
        chk("rst_rgb",   {8'd0, rgb},    32'd0);
        chk("rst_led0",  {31'd0, led[0]}, 32'd0);
        chk("rst_led1",  {31'd0, led[1]}, 32'd0);
        repeat (3) @(posedge clk);
        #2 key[0] = 1'b1;
    endtask

    initial begin
        int guard;
        key = 2'b11;
        sw  = 4'd0;
        repeat (3) @(posedge clk);
        reset_pulse();
        repeat (8) @(posedge clk);
        #2 sw = 4'b1010;
        @(posedge clk); #2;
        chk("sw_led", {28'd0, led[5:2]}, 32'b1010);
        chk("led0_key", {31'd0, led[0]}, 32'd1);
        guard = 0;
        while (pos != 40 * HTOT + 100 && guard < 20000) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("reach_mid", {31'd0, guard < 20000}, 32'd1);
        reset_pulse();
        repeat (242 * HTOT + 20) @(posedge clk);
        @(negedge clk); #1;
        chk("vs_count", vs_n, 32'd2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
